any1_irq_nest: RTL and testbench

Interrupt nesting controller placed between the any1 PIC outputs (irq level, cause, nmi) and the CPU interrupt inputs. It presents a PIC request to the CPU only when that request's level exceeds both a software threshold and the level of the interrupt currently in service. It keeps an in-service stack of (level, cause) pairs: the stack is pushed on CPU acknowledge and popped on end-of-interrupt (EOI). A small memory-mapped register slave gives software the threshold, status and an EOI port.

---
 rtl/any1_irq_nest.sv | 183 ++++++++++++++++++
 tb/tb_any1_irq_nest.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/any1_irq_nest.sv
// any1_irq_nest: interrupt nesting controller between the any1 PIC and the CPU.
// A PIC request is presented only when its level beats both the software
// threshold and the level currently in service. Acknowledged interrupts are
// pushed onto an in-service stack and popped again on end-of-interrupt.
//
// state      | meaning
// S_IDLE     | nothing presented, waiting for a qualifying request
// S_PRESENT  | irq_o/cause_o held for the CPU until ack or withdrawal
module any1_irq_nest #(
    parameter logic [31:0] pIOAddress = 32'hFFDC_1000,
    parameter int          pDepth     = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        wr_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    input  logic [3:0]  pic_irq_i,
    input  logic [7:0]  pic_cause_i,
    input  logic        pic_nmi_i,
    output logic [3:0]  irq_o,
    output logic [7:0]  cause_o,
    output logic        nmi_o,
    input  logic        irq_ack_i,
    input  logic        eoi_i
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;
    localparam logic [3:0] DEPTH_MAX = 4'(pDepth);

    logic [0:0]  state;
    logic [3:0]  threshold;
    logic [3:0]  depth;
    logic        ovf;
    logic        unf;
    logic        rdy;

    logic [3:0]  stk_lvl   [pDepth];
    logic [7:0]  stk_cause [pDepth];

    logic        cs;
    logic        wr_en;
    logic [1:0]  reg_sel;
    logic        push;
    logic        pop;
    logic        stk_we;
    logic [3:0]  stk_idx;
    logic [3:0]  top_lvl;
    logic [7:0]  top_cause;
    logic [3:0]  eff;
    logic        qualify;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign cs      = cyc_i & stb_i & (adr_i[31:8] == pIOAddress[31:8]);
    assign wr_en   = cs & wr_i;
    assign reg_sel = adr_i[3:2];
    assign ack_o   = cs & (wr_i | rdy);

    // Two pop sources in one cycle collapse into a single pop.
    assign pop  = eoi_i | (wr_en & (reg_sel == 2'd2));
    assign push = (state == S_PRESENT) & irq_ack_i;

    // A push that coincides with a pop on a non-empty stack overwrites the top.
    assign stk_idx = (pop && depth != 4'd0) ? depth - 4'd1 : depth;
    assign stk_we  = push & (pop | (depth != DEPTH_MAX));

    assign eff     = (threshold > top_lvl) ? threshold : top_lvl;
    assign qualify = pic_irq_i > eff;

    assign unused_bits = ^{adr_i[7:4], adr_i[1:0], dat_i[31:4]};

    // Top-of-stack lookup; an empty stack reads as level 0, cause 0.
    always_comb begin
        top_lvl   = 4'd0;
        top_cause = 8'd0;
        for (int i = 0; i < pDepth; i++) begin
            if (depth != 4'd0 && 4'(i) == depth - 4'd1) begin
                top_lvl   = stk_lvl[i];
                top_cause = stk_cause[i];
            end
        end
    end

    // Register read mux.
    always_comb begin
        rd_data = 32'd0;
        case (reg_sel)
            2'd0:    rd_data = {28'd0, threshold};
            2'd1:    rd_data = {14'd0, unf, ovf, 4'd0, depth, 4'd0, top_lvl};
            2'd2:    rd_data = {24'd0, top_cause};
            default: rd_data = 32'd0;
        endcase
    end

    // Stack storage; contents beyond depth are don't-care so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (stk_we) begin
            for (int i = 0; i < pDepth; i++) begin
                if (4'(i) == stk_idx) begin
                    stk_lvl[i]   <= irq_o;
                    stk_cause[i] <= cause_o;
                end
            end
        end
    end

    // Stack depth and overflow/underflow flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            depth <= 4'd0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (wr_en && reg_sel == 2'd1) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (push && pop) begin
                if (depth == 4'd0)
                    depth <= 4'd1;
            end else if (push) begin
                if (depth == DEPTH_MAX)
                    ovf <= 1'b1;
                else
                    depth <= depth + 4'd1;
            end else if (pop) begin
                if (depth == 4'd0)
                    unf <= 1'b1;
                else
                    depth <= depth - 4'd1;
            end
        end
    end

    // Presentation FSM; acknowledge wins over withdrawal in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            irq_o   <= 4'd0;
            cause_o <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (qualify) begin
                        irq_o   <= pic_irq_i;
                        cause_o <= pic_cause_i;
                        state   <= S_PRESENT;
                    end
                end
                default: begin
                    if (irq_ack_i || !qualify) begin
                        irq_o   <= 4'd0;
                        cause_o <= 8'd0;
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Bus slave registers, read data pipeline and the ungated nmi path.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            threshold <= 4'd0;
            rdy       <= 1'b0;
            dat_o     <= 32'd0;
            nmi_o     <= 1'b0;
        end else begin
            rdy   <= cs;
            dat_o <= cs ? rd_data : 32'd0;
            nmi_o <= pic_nmi_i;
            if (wr_en && reg_sel == 2'd0)
                threshold <= dat_i[3:0];
        end
    end

endmodule

// File: tb/tb_any1_irq_nest.sv
// Directed bench for any1_irq_nest: a vector table for present/ack/EOI and
// register traffic, plus hand sequences for overflow, reset and nmi.
module tb_any1_irq_nest;

    localparam logic [31:0] BASE = 32'hFFDC_1000;
    localparam int OP_STEP = 0;
    localparam int OP_CHK  = 1;
    localparam int OP_WR   = 2;
    localparam int OP_RD   = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cyc_i, stb_i, wr_i;
    logic [31:0] adr_i, dat_i;
    logic        ack_o;
    logic [31:0] dat_o;
    logic [3:0]  pic_irq_i;
    logic [7:0]  pic_cause_i;
    logic        pic_nmi_i;
    logic [3:0]  irq_o;
    logic [7:0]  cause_o;
    logic        nmi_o;
    logic        irq_ack_i, eoi_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          op;
        logic [3:0]  irq;
        logic [7:0]  cause;
        logic        ack;
        logic        eoi;
        logic [7:0]  off;
        logic [31:0] data;
        logic [3:0]  exp_irq;
        logic [7:0]  exp_cause;
        string       name;
    } vec_t;

    vec_t vecs[$];

    any1_irq_nest #(.pIOAddress(BASE), .pDepth(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cyc_i(cyc_i), .stb_i(stb_i), .wr_i(wr_i),
        .adr_i(adr_i), .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o),
        .pic_irq_i(pic_irq_i), .pic_cause_i(pic_cause_i), .pic_nmi_i(pic_nmi_i),
        .irq_o(irq_o), .cause_o(cause_o), .nmi_o(nmi_o),
        .irq_ack_i(irq_ack_i), .eoi_i(eoi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t vs(input logic [3:0] irq, input logic [7:0] c, input logic ack,
                                input logic eoi, input logic [3:0] ei, input logic [7:0] ec,
                                input string nm);
        vec_t v;
        v.op = OP_STEP; v.irq = irq; v.cause = c; v.ack = ack; v.eoi = eoi;
        v.off = 8'd0; v.data = 32'd0; v.exp_irq = ei; v.exp_cause = ec; v.name = nm;
        return v;
    endfunction

    function automatic vec_t vc(input logic [3:0] ei, input logic [7:0] ec, input string nm);
        vec_t v;
        v = vs(4'd0, 8'd0, 1'b0, 1'b0, ei, ec, nm);
        v.op = OP_CHK;
        return v;
    endfunction

    function automatic vec_t vw(input logic [7:0] off, input logic [31:0] d,
                                input logic [3:0] irq, input logic [7:0] c);
        vec_t v;
        v = vs(irq, c, 1'b0, 1'b0, 4'd0, 8'd0, "write");
        v.op = OP_WR; v.off = off; v.data = d;
        return v;
    endfunction

    function automatic vec_t vr(input logic [7:0] off, input logic [31:0] d, input string nm);
        vec_t v;
        v = vs(4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, nm);
        v.op = OP_RD; v.off = off; v.data = d;
        return v;
    endfunction

    // One clock of PIC/CPU stimulus; ack and eoi are single-cycle pulses.
    task automatic step(input logic [3:0] irq, input logic [7:0] c, input logic ack, input logic eoi);
        pic_irq_i = irq; pic_cause_i = c; irq_ack_i = ack; eoi_i = eoi;
        @(negedge clk_i);
        irq_ack_i = 1'b0; eoi_i = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
        cyc_i = 1'b1; stb_i = 1'b1; wr_i = 1'b1; adr_i = BASE | {24'd0, off}; dat_i = d;
        #1;
        chk("write_ack", {31'd0, ack_o}, 32'd1);
        @(negedge clk_i);
        cyc_i = 1'b0; stb_i = 1'b0; wr_i = 1'b0; adr_i = 32'd0; dat_i = 32'd0;
    endtask

    task automatic bus_read(input logic [7:0] off, input logic [31:0] exp, input string nm);
        cyc_i = 1'b1; stb_i = 1'b1; wr_i = 1'b0; adr_i = BASE | {24'd0, off};
        @(negedge clk_i);
        chk({nm, "_ack"}, {31'd0, ack_o}, 32'd1);
        chk(nm, dat_o, exp);
        cyc_i = 1'b0; stb_i = 1'b0; adr_i = 32'd0;
    endtask

    initial begin
        rst_ni = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; wr_i = 1'b0;
        adr_i = 32'd0; dat_i = 32'd0; pic_irq_i = 4'd0; pic_cause_i = 8'd0;
        pic_nmi_i = 1'b1; irq_ack_i = 1'b0; eoi_i = 1'b0;

        // basic present / acknowledge
        vecs.push_back(vr(8'h04, 32'h0000_0000, "status_reset"));
        vecs.push_back(vr(8'h00, 32'h0000_0000, "thr_reset"));
        vecs.push_back(vs(4'd3, 8'h21, 1'b0, 1'b0, 4'd3, 8'h21, "present_3"));
        vecs.push_back(vs(4'd3, 8'h21, 1'b1, 1'b0, 4'd0, 8'h00, "ack_3"));
        vecs.push_back(vr(8'h04, 32'h0000_0103, "status_d1_t3"));
        vecs.push_back(vr(8'h08, 32'h0000_0021, "cause_21"));
        // nesting
        vecs.push_back(vs(4'd2, 8'h12, 1'b0, 1'b0, 4'd0, 8'h00, "lvl2_masked"));
        vecs.push_back(vs(4'd5, 8'h55, 1'b0, 1'b0, 4'd5, 8'h55, "present_5"));
        vecs.push_back(vs(4'd5, 8'h55, 1'b1, 1'b0, 4'd0, 8'h00, "ack_5"));
        vecs.push_back(vs(4'd5, 8'h55, 1'b0, 1'b0, 4'd0, 8'h00, "lvl5_eq_top"));
        vecs.push_back(vr(8'h04, 32'h0000_0205, "status_d2_t5"));
        vecs.push_back(vr(8'h08, 32'h0000_0055, "cause_55"));
        vecs.push_back(vs(4'd0, 8'h00, 1'b0, 1'b1, 4'd0, 8'h00, "eoi_pin"));
        vecs.push_back(vr(8'h04, 32'h0000_0103, "status_after_eoi"));
        vecs.push_back(vs(4'd2, 8'h12, 1'b0, 1'b0, 4'd0, 8'h00, "lvl2_still_masked"));
        vecs.push_back(vw(8'h08, 32'd0, 4'd2, 8'h12));
        vecs.push_back(vc(4'd0, 8'h00, "no_present_at_eoi_edge"));
        vecs.push_back(vs(4'd2, 8'h12, 1'b0, 1'b0, 4'd2, 8'h12, "present_2_empty"));
        // withdraw
        vecs.push_back(vs(4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, "withdraw"));
        vecs.push_back(vr(8'h04, 32'h0000_0000, "status_no_push"));
        // threshold
        vecs.push_back(vw(8'h00, 32'd6, 4'd0, 8'h00));
        vecs.push_back(vr(8'h00, 32'h0000_0006, "thr_6"));
        vecs.push_back(vs(4'd6, 8'h66, 1'b0, 1'b0, 4'd0, 8'h00, "lvl6_at_thr"));
        vecs.push_back(vs(4'd7, 8'h77, 1'b0, 1'b0, 4'd7, 8'h77, "lvl7_over_thr"));
        vecs.push_back(vs(4'd7, 8'h77, 1'b1, 1'b1, 4'd0, 8'h00, "ack_eoi_empty"));
        vecs.push_back(vr(8'h04, 32'h0000_0107, "status_push_no_unf"));
        vecs.push_back(vs(4'd0, 8'h00, 1'b0, 1'b1, 4'd0, 8'h00, "eoi_to_empty"));
        vecs.push_back(vw(8'h00, 32'd2, 4'd3, 8'h33));
        vecs.push_back(vc(4'd0, 8'h00, "thr_write_edge_old_thr"));
        vecs.push_back(vs(4'd3, 8'h33, 1'b0, 1'b0, 4'd3, 8'h33, "thr_new_applies"));
        // ack wins over withdrawal
        vecs.push_back(vs(4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00, "ack_and_withdraw"));
        vecs.push_back(vr(8'h04, 32'h0000_0103, "status_ack_wins"));
        vecs.push_back(vr(8'h08, 32'h0000_0033, "cause_33"));
        // simultaneous ack + eoi at depth 2
        vecs.push_back(vs(4'd4, 8'h44, 1'b0, 1'b0, 4'd4, 8'h44, "present_4"));
        vecs.push_back(vs(4'd4, 8'h44, 1'b1, 1'b0, 4'd0, 8'h00, "ack_4"));
        vecs.push_back(vs(4'd6, 8'h66, 1'b0, 1'b0, 4'd6, 8'h66, "present_6"));
        vecs.push_back(vs(4'd6, 8'h66, 1'b1, 1'b1, 4'd0, 8'h00, "ack_eoi_d2"));
        vecs.push_back(vr(8'h04, 32'h0000_0206, "status_replaced"));
        vecs.push_back(vr(8'h08, 32'h0000_0066, "cause_replaced"));

        repeat (2) @(negedge clk_i);
        chk("rst_irq", {28'd0, irq_o}, 32'd0);
        chk("rst_cause", {24'd0, cause_o}, 32'd0);
        chk("rst_nmi", {31'd0, nmi_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        rst_ni = 1'b1; pic_nmi_i = 1'b0;
        @(negedge clk_i);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_STEP: begin
                    step(vecs[i].irq, vecs[i].cause, vecs[i].ack, vecs[i].eoi);
                    chk(vecs[i].name, {20'd0, irq_o, cause_o},
                        {20'd0, vecs[i].exp_irq, vecs[i].exp_cause});
                end
                OP_CHK:
                    chk(vecs[i].name, {20'd0, irq_o, cause_o},
                        {20'd0, vecs[i].exp_irq, vecs[i].exp_cause});
                OP_WR: begin
                    pic_irq_i = vecs[i].irq; pic_cause_i = vecs[i].cause;
                    bus_write(vecs[i].off, vecs[i].data);
                end
                default: begin
                    pic_irq_i = vecs[i].irq; pic_cause_i = vecs[i].cause;
                    bus_read(vecs[i].off, vecs[i].data, vecs[i].name);
                end
            endcase
        end

        // Overflow: empty the stack, then nine ascending pushes into eight entries.
        step(4'd0, 8'h00, 1'b0, 1'b1);
        step(4'd0, 8'h00, 1'b0, 1'b1);
        bus_write(8'h00, 32'd0);
        for (int lv = 1; lv <= 9; lv++) begin
            step(4'(lv), 8'(lv), 1'b0, 1'b0);
            chk("ovf_present", {28'd0, irq_o}, 32'(lv));
            step(4'(lv), 8'(lv), 1'b1, 1'b0);
            chk("ovf_ack_clear", {28'd0, irq_o}, 32'd0);
        end
        step(4'd0, 8'h00, 1'b0, 1'b0);
        bus_read(8'h04, 32'h0001_0808, "status_ovf");
        bus_read(8'h08, 32'h0000_0008, "cause_top_kept");
        for (int k = 0; k < 9; k++)
            step(4'd0, 8'h00, 1'b0, 1'b1);
        bus_read(8'h04, 32'h0003_0000, "status_ovf_unf");
        bus_write(8'h04, 32'hFFFF_FFFF);
        bus_read(8'h04, 32'h0000_0000, "status_cleared");

        // Reset during PRESENT with a simultaneous acknowledge.
        bus_write(8'h00, 32'd3);
        step(4'd5, 8'h05, 1'b0, 1'b0);
        chk("pre_rst_present5", {28'd0, irq_o}, 32'd5);
        step(4'd5, 8'h05, 1'b1, 1'b0);
        step(4'd7, 8'h07, 1'b0, 1'b0);
        chk("pre_rst_present7", {20'd0, irq_o, cause_o}, 32'h0000_0707);
        rst_ni = 1'b0;
        step(4'd7, 8'h07, 1'b1, 1'b0);
        chk("rst_mid_irq", {20'd0, irq_o, cause_o}, 32'd0);
        rst_ni = 1'b1;
        step(4'd0, 8'h00, 1'b0, 1'b0);
        bus_read(8'h04, 32'h0000_0000, "status_after_rst");
        bus_read(8'h00, 32'h0000_0000, "thr_after_rst");

        // nmi passes straight through one cycle later, whatever the threshold.
        bus_write(8'h00, 32'd15);
        pic_nmi_i = 1'b1;
        step(4'd15, 8'hFF, 1'b0, 1'b0);
        chk("nmi_high", {31'd0, nmi_o}, 32'd1);
        chk("lvl15_masked", {28'd0, irq_o}, 32'd0);
        pic_nmi_i = 1'b0;
        step(4'd0, 8'h00, 1'b0, 1'b0);
        chk("nmi_low", {31'd0, nmi_o}, 32'd0);
        chk("dat_idle", dat_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
